// File: rtl/exp_job_sequencer.sv
// exp_job_sequencer: 4-deep operand FIFO feeding a start/done exp engine, one job at a time, results in order.
// Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
module exp_job_sequencer #(
  parameter int XW = 16,
  parameter int RW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [XW-1:0] in_data,
  output logic          in_ready,
  output logic          eng_start,
  output logic [XW-1:0] eng_x,
  input  logic          eng_done,
  input  logic [RW-1:0] eng_result,
  output logic          out_valid,
  output logic [RW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          err
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, CAPTURE} state_t;
  state_t state, state_n;
  logic [XW-1:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] count;
  logic push, pop, cap, timeout;
  assign in_ready = count < 3'd4;
  assign push = in_valid && in_ready;
  assign pop = state == IDLE && count != 3'd0 && eng_done;
  assign cap = state == CAPTURE && (!out_valid || out_ready);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = pop ? LAUNCH : IDLE;
      LAUNCH:    state_n = WAIT_BUSY;
      WAIT_BUSY: state_n = timeout ? IDLE : eng_done ? WAIT_BUSY : WAIT_DONE;
      WAIT_DONE: state_n = timeout ? IDLE : eng_done ? CAPTURE : WAIT_DONE;
      CAPTURE:   state_n = cap ? IDLE : CAPTURE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      eng_start <= 1'b0;
      eng_x <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_n;
      wp <= push ? wp + 2'd1 : wp;
      rp <= pop ? rp + 2'd1 : rp;
      count <= count + {2'b0, push} - {2'b0, pop};
      eng_start <= state_n == LAUNCH;
      eng_x <= pop ? mem[rp] : eng_x;
      out_valid <= cap ? 1'b1 : (out_valid && out_ready) ? 1'b0 : out_valid;
      out_data <= cap ? eng_result : out_data;
    end
`ifdef SEQ_TIMEOUT_EN
  logic [7:0] wd;
  logic err_q;
  // Counts from the LAUNCH cycle so err lands 255 cycles after LAUNCH is entered
  assign timeout = (state == WAIT_BUSY || state == WAIT_DONE) && wd == 8'd254;
  assign err = err_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wd <= '0;
      err_q <= 1'b0;
    end else begin
      wd <= state_n == LAUNCH ? 8'd0 : (state == LAUNCH || state == WAIT_BUSY || state == WAIT_DONE) ? wd + 8'd1 : wd;
      err_q <= err_q || timeout;
    end
`else
  assign timeout = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_exp_job_sequencer.sv
// tb_exp_job_sequencer: scoreboard bench with a behavioural exp engine (done low 10 cycles, result = x+1).
module tb_exp_job_sequencer;
  localparam int XW = 16;
  localparam int RW = 18;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0, hang = 1'b0;
  logic in_ready, eng_start, eng_done, out_valid, busy, err;
  logic [XW-1:0] in_data = '0, eng_x;
  logic [RW-1:0] eng_result, out_data, exp_v;
  logic [RW-1:0] sb [$];
  int tests = 0, fails = 0, n_starts = 0, ecnt;
  always #5 clk = ~clk;
  exp_job_sequencer #(.XW(XW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done), .eng_result(eng_result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy), .err(err)
  );
  always @(posedge clk or negedge rst)
    if (!rst) begin
      eng_done <= 1'b1;
      eng_result <= '0;
      ecnt <= 0;
    end else if (eng_start) begin
      eng_done <= 1'b0;
      eng_result <= RW'(eng_x) + RW'(1);
      ecnt <= hang ? 0 : 10;
    end else if (ecnt != 0) begin
      ecnt <= ecnt - 1;
      if (ecnt == 1) eng_done <= 1'b1;
    end
  always @(posedge clk) if (rst && eng_start) n_starts++;

  task automatic test_reset;
    rst = 1'b0;
    #2;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (eng_start !== 1'b0 || eng_x !== '0) begin fails++; $display("FAIL reset_eng got start=%b x=%h exp 0/0", eng_start, eng_x); end
    tests++; if (out_valid !== 1'b0 || out_data !== '0) begin fails++; $display("FAIL reset_out got v=%b d=%h exp 0/0", out_valid, out_data); end
    tests++; if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_status got busy=%b err=%b exp 0/0", busy, err); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single;
    int s0 = n_starts;
    bit seen = 0, prev_start = 0;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = 16'h0003;
    if (in_ready) sb.push_back(18'h00004);
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (prev_start) begin
        tests++; if (eng_start !== 1'b0) begin fails++; $display("FAIL single_pulse_width got=%b exp=0", eng_start); end
      end
      if (eng_start) begin
        tests++; if (eng_x !== 16'h0003) begin fails++; $display("FAIL single_eng_x got=%h exp=0003", eng_x); end
      end
      prev_start = eng_start;
      if (out_valid && out_ready) begin
        seen = 1;
        tests++;
        if (sb.size() == 0) begin fails++; $display("FAIL single_unexpected got=%h exp=none", out_data); end
        else begin exp_v = sb.pop_front(); if (out_data !== exp_v) begin fails++; $display("FAIL single_out got=%h exp=%h", out_data, exp_v); end end
      end
      @(negedge clk);
    end
    tests++; if (!seen) begin fails++; $display("FAIL single_timeout got=no_output exp=out_valid"); end
    tests++; if (n_starts - s0 !== 1) begin fails++; $display("FAIL single_starts got=%0d exp=1", n_starts - s0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = XW'(i);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_accept%0d got=%b exp=1", i, in_ready); end
      else sb.push_back(RW'(i) + RW'(1));
    end
    @(negedge clk); in_valid = 1'b0;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full got in_ready=%b exp=0", in_ready); end
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      if (out_valid && out_ready) begin
        exp_v = sb.pop_front(); tests++;
        if (out_data !== exp_v) begin fails++; $display("FAIL b2b_order got=%h exp=%h", out_data, exp_v); end
      end
      @(negedge clk);
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_drain got %0d left exp=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_stall;
    int s0 = n_starts;
    bit seen = 0;
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = XW'(i * 16);
      if (in_ready) sb.push_back(RW'(i * 16) + RW'(1));
    end
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin @(negedge clk); seen = out_valid; end
    tests++; if (!seen) begin fails++; $display("FAIL stall_timeout got=no_output exp=out_valid"); end
    repeat (60) @(negedge clk);
    tests++; if (out_valid !== 1'b1 || out_data !== 18'h00011) begin fails++; $display("FAIL stall_hold got v=%b d=%h exp 1/00011", out_valid, out_data); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stall_capture got busy=%b exp=1", busy); end
    tests++; if (n_starts - s0 !== 2) begin fails++; $display("FAIL stall_starts got=%0d exp=2", n_starts - s0); end
    out_ready = 1'b1;
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      if (out_valid && out_ready) begin
        exp_v = sb.pop_front(); tests++;
        if (out_data !== exp_v) begin fails++; $display("FAIL stall_order got=%h exp=%h", out_data, exp_v); end
      end
      @(negedge clk);
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL stall_drain got %0d left exp=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_reset_mid;
    bit seen = 0, stray = 0;
    int s0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = XW'(16'h40 + i * 16);
    end
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      seen = busy && !eng_done && !eng_start;
      @(negedge clk);
    end
    tests++; if (!seen || eng_done !== 1'b0) begin fails++; $display("FAIL rmid_wait got done=%b exp=0", eng_done); end
    rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || eng_start !== 1'b0) begin fails++; $display("FAIL rmid_ctrl got v=%b busy=%b start=%b exp 0/0/0", out_valid, busy, eng_start); end
    tests++; if (eng_x !== '0 || out_data !== '0 || in_ready !== 1'b1) begin fails++; $display("FAIL rmid_data got x=%h d=%h rdy=%b exp 0/0/1", eng_x, out_data, in_ready); end
    @(negedge clk); rst = 1'b1;
    s0 = n_starts;
    repeat (40) begin @(negedge clk); if (out_valid) stray = 1; end
    tests++; if (stray || n_starts != s0) begin fails++; $display("FAIL rmid_flush got stray=%b starts=%0d exp 0/0", stray, n_starts - s0); end
  endtask

  task automatic test_timeout;
    bit seen = 0;
    hang = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = 16'h0070;
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (eng_start) seen = 1; else @(negedge clk);
    end
    tests++; if (!seen) begin fails++; $display("FAIL to_launch got=no_start exp=start"); end
`ifdef SEQ_TIMEOUT_EN
    repeat (254) @(negedge clk);
    tests++; if (err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL to_early got err=%b busy=%b exp 0/1", err, busy); end
    @(negedge clk);
    tests++; if (err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL to_fire got err=%b busy=%b exp 1/0", err, busy); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL to_nocap got out_valid=%b exp=0", out_valid); end
    repeat (5) @(negedge clk);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_sticky got err=%b exp=1", err); end
`else
    repeat (300) @(negedge clk);
    tests++; if (err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL to_wait got err=%b busy=%b exp 0/1", err, busy); end
`endif
    hang = 1'b0;
    rst = 1'b0;
    #1;
    tests++; if (err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL to_reset got err=%b busy=%b exp 0/0", err, busy); end
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
